// File: rtl/rfp_gpi_matrix.sv
// GPI routing matrix: synchronizes accessory inputs, routes them to RFIC control outputs.
// Shadow/active route tables; optional glitch filter under RFP_GPI_FILTER_EN.
//
// Ports:
//   clk, rstn       clock and synchronous active-low reset
//   input_lines     asynchronous accessory inputs
//   output_lines    routed, registered control outputs
//   cfg_wr          configuration write strobe
//   input_select    source code for the write
//   output_select   destination entry, or all-ones to commit shadow to active
//   cfg_pending     shadow table differs from active table
module rfp_gpi_matrix #(
  parameter int NUM_IN     = 6,
  parameter int NUM_OUT    = 8,
  parameter int SEL_W      = 4,
  parameter int FILTER_CNT = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IN-1:0]  input_lines,
  output logic [NUM_OUT-1:0] output_lines,
  input  logic               cfg_wr,
  input  logic [SEL_W-1:0]   input_select,
  input  logic [SEL_W-1:0]   output_select,
  output logic               cfg_pending
);

  localparam logic [SEL_W-1:0] CODE_ZERO   = SEL_W'(NUM_IN);
  localparam logic [SEL_W-1:0] CODE_ONE    = SEL_W'(NUM_IN + 1);
  localparam logic [SEL_W-1:0] CODE_COMMIT = '1;
  localparam logic [SEL_W-1:0] OUT_LIMIT   = SEL_W'(NUM_OUT);

  logic [NUM_IN-1:0] sync1_q;
  logic [NUM_IN-1:0] sync2_q;
  logic [NUM_IN-1:0] filt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= input_lines;
      sync2_q <= sync1_q;
    end
  end

`ifdef RFP_GPI_FILTER_EN
  localparam logic [7:0] CNT_LAST = 8'(FILTER_CNT - 1);

  logic [NUM_IN-1:0]      filt_q;
  logic [NUM_IN-1:0][7:0] cnt_q;

  // The counter runs only while the synchronized value disagrees with
  // the filtered one; reaching FILTER_CNT disagreeing cycles flips it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  logic [NUM_OUT-1:0][SEL_W-1:0] shadow_q;
  logic [NUM_OUT-1:0][SEL_W-1:0] shadow_d;
  logic [NUM_OUT-1:0][SEL_W-1:0] active_q;
  logic [NUM_OUT-1:0][SEL_W-1:0] active_d;
  logic                          wr_entry;
  logic                          wr_commit;

  assign wr_entry  = cfg_wr && (output_select < OUT_LIMIT);
  assign wr_commit = cfg_wr && (output_select == CODE_COMMIT);

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_entry && output_select == SEL_W'(k)) begin
        shadow_d[k] = input_select;
      end
    end
    active_d = wr_commit ? shadow_q : active_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_q    <= {NUM_OUT{CODE_ZERO}};
      active_q    <= {NUM_OUT{CODE_ZERO}};
      cfg_pending <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_pending <= (shadow_d != active_d);
    end
  end

  logic [NUM_OUT-1:0] route;

  // Codes at or above NUM_IN other than CODE_ONE all resolve to 0.
  always_comb begin
    route = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (active_q[k] == SEL_W'(i)) begin
          route[k] = filt[i];
        end
      end
      if (active_q[k] == CODE_ONE) begin
        route[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      output_lines <= '0;
    end else begin
      output_lines <= route;
    end
  end

endmodule

// File: tb/tb_rfp_gpi_matrix.sv
// Directed testbench for rfp_gpi_matrix.
// Linear directed steps with immediate-assertion checks.
module tb_rfp_gpi_matrix;

`ifdef RFP_GPI_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       rstn;
  logic [5:0] input_lines;
  logic [7:0] output_lines;
  logic       cfg_wr;
  logic [3:0] input_select;
  logic [3:0] output_select;
  logic       cfg_pending;

  int vectors;
  int miscompares;

  rfp_gpi_matrix dut (
    .clk          (clk),
    .rstn         (rstn),
    .input_lines  (input_lines),
    .output_lines (output_lines),
    .cfg_wr       (cfg_wr),
    .input_select (input_select),
    .output_select(output_select),
    .cfg_pending  (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] os, input logic [3:0] is);
    cfg_wr        = 1'b1;
    output_select = os;
    input_select  = is;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rstn          = 1'b0;
    cfg_wr        = 1'b0;
    input_select  = '0;
    output_select = '0;
    input_lines   = '0;
    repeat (3) step();
    chk("rst_out", output_lines, 8'h00);
    chk("rst_pend", {7'd0, cfg_pending}, 8'h00);

    rstn        = 1'b1;
    input_lines = 6'h3F;
    repeat (12) step();
    chk("idle_out", output_lines, 8'h00);
    chk("idle_pend", {7'd0, cfg_pending}, 8'h00);
    input_lines = 6'h00;
    repeat (12) step();

    cfg(4'd2, 4'd0);
    chk("wr2_pend", {7'd0, cfg_pending}, 8'h01);
    chk("wr2_out", output_lines, 8'h00);
    cfg(4'd15, 4'd0);
    chk("c1_pend", {7'd0, cfg_pending}, 8'h00);
    chk("c1_out", output_lines, 8'h00);
    step();
    chk("c1_out2", output_lines, 8'h00);

    input_lines = 6'h01;
    for (int c = 1; c <= LAT; c++) begin
      step();
      chk($sformatf("rise_c%0d", c), output_lines,
          (c == LAT) ? 8'h04 : 8'h00);
    end

    cfg(4'd5, 4'd0);
    chk("wr5_pend", {7'd0, cfg_pending}, 8'h01);
    chk("wr5_out", output_lines, 8'h04);
    cfg(4'd15, 4'd0);
    chk("c2_pend", {7'd0, cfg_pending}, 8'h00);
    chk("c2_edge", output_lines, 8'h04);
    step();
    chk("c2_next", output_lines, 8'h24);

    cfg(4'd7, 4'd7);
    chk("wr7_pend", {7'd0, cfg_pending}, 8'h01);
    chk("wr7_out", output_lines, 8'h24);
    repeat (2) step();
    chk("wr7_hold", output_lines, 8'h24);
    chk("wr7_pend2", {7'd0, cfg_pending}, 8'h01);
    cfg(4'd15, 4'd0);
    chk("c3_pend", {7'd0, cfg_pending}, 8'h00);
    chk("c3_edge", output_lines, 8'h24);
    step();
    chk("c3_next", output_lines, 8'hA4);

    cfg(4'd9, 4'd7);
    chk("ign9_pend", {7'd0, cfg_pending}, 8'h00);
    cfg(4'd10, 4'd7);
    chk("ign10_pend", {7'd0, cfg_pending}, 8'h00);
    cfg(4'd14, 4'd7);
    chk("ign14_pend", {7'd0, cfg_pending}, 8'h00);
    cfg(4'd15, 4'd0);
    step();
    chk("ign_out", output_lines, 8'hA4);

    cfg(4'd3, 4'd7);
    cfg(4'd3, 4'd1);
    chk("b2b_pend", {7'd0, cfg_pending}, 8'h01);
    cfg(4'd15, 4'd0);
    step();
    chk("b2b_out", output_lines, 8'hA4);

    input_lines = 6'h02;
    for (int k = 0; k < 8; k++) begin
      cfg(4'(k), 4'd1);
    end
    cfg(4'd15, 4'd0);
    step();
    chk("all_out", output_lines, 8'hFF);

    cfg(4'd0, 4'd7);
    chk("uncm_pend", {7'd0, cfg_pending}, 8'h01);
    chk("uncm_out", output_lines, 8'hFF);
    rstn = 1'b0;
    step();
    chk("mid_rst_out", output_lines, 8'h00);
    chk("mid_rst_pend", {7'd0, cfg_pending}, 8'h00);
    cfg(4'd4, 4'd7);
    cfg(4'd15, 4'd0);
    chk("rst_wr_out", output_lines, 8'h00);
    rstn = 1'b1;
    step();
    chk("post_rst_pend", {7'd0, cfg_pending}, 8'h00);
    cfg(4'd15, 4'd0);
    repeat (LAT + 2) step();
    chk("post_rst_out", output_lines, 8'h00);

    cfg(4'd0, 4'd2);
    cfg(4'd15, 4'd0);
    input_lines = 6'h00;
    repeat (12) step();
    chk("pulse_base", output_lines, 8'h00);

`ifdef RFP_GPI_FILTER_EN
    input_lines = 6'h04;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 3) input_lines = 6'h00;
      chk($sformatf("p3_c%0d", c), output_lines, 8'h00);
    end
    input_lines = 6'h04;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 4) input_lines = 6'h00;
      chk($sformatf("p4_c%0d", c), output_lines,
          (c >= 7 && c <= 10) ? 8'h01 : 8'h00);
    end
`else
    input_lines = 6'h04;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) input_lines = 6'h00;
      chk($sformatf("p1_c%0d", c), output_lines,
          (c == 3) ? 8'h01 : 8'h00);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
